lenet_layer1_scheduler: RTL and testbench

LENET_LAYER1_SCHEDULER -- requirements
Module: lenet_layer1_scheduler

---
 rtl/lenet_layer1_scheduler.sv | 167 ++++++++++++++++
 tb/tb_lenet_layer1_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_layer1_scheduler.sv
// LeNet layer-1 scheduler: streams one input frame to the broadcast conv
// channels and gathers their pooled outputs into the result memory.
module lenet_layer1_scheduler #(
  parameter int N_CH        = 6,
  parameter int MAPSIZE     = 32,
  parameter int POOL_OUT    = 14,
  parameter int LOAD_CYCLES = 32,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              img_rd_en,
  output logic [9:0]        img_rd_addr,
  input  logic [7:0]        img_rd_data,
  output logic              ch_start,
  output logic              ch_valid,
  output logic [7:0]        ch_pixel,
  input  logic [N_CH-1:0]   ch_valid_in,
  input  logic [N_CH*8-1:0] ch_pixel_in,
  input  logic [N_CH-1:0]   ch_layer_done,
  output logic              out_wr_en,
  output logic [7:0]        out_wr_addr,
  output logic [N_CH*8-1:0] out_wr_data,
  output logic              busy,
  output logic              done,
  output logic              error
);
  localparam int NPIX = MAPSIZE * MAPSIZE;
  localparam int NOUT = POOL_OUT * POOL_OUT;
  localparam int LW   = $clog2(LOAD_CYCLES + 1);
  localparam int RW   = $clog2(NPIX + 1);
  localparam int DW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    LOAD_WAIT,
    IDLE,
    ARM,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [LW-1:0]   load_cnt;
  logic [RW-1:0]   rd_cnt;
  logic [7:0]      out_cnt;
  logic [DW-1:0]   drain_cnt;
  logic [N_CH-1:0] done_flags;
  logic            pending;
  logic            accept;
  logic            collect;
  logic            all_v;
  logic            any_v;
  logic            rd_go;
  logic            wr_go;
  logic            fault;
  logic            drain_ok;
  logic            timeout_hit;

  assign all_v       = &ch_valid_in;
  assign any_v       = |ch_valid_in;
  assign collect     = (state == STREAM) || (state == DRAIN);
  assign accept      = (state == IDLE) && (start || pending);
  assign rd_go       = (state == STREAM) && !stall
                       && (rd_cnt < RW'(NPIX));
  assign wr_go       = collect && all_v && (out_cnt < 8'(NOUT));
  assign fault       = collect && any_v
                       && (!all_v || (out_cnt >= 8'(NOUT)));
  assign drain_ok    = (out_cnt == 8'(NOUT)) && (&done_flags)
                       && !out_wr_en;
  assign timeout_hit = (state == DRAIN) && !drain_ok
                       && (drain_cnt == DW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_WAIT;
    else     state <= state_nx;
  end

  // Strobes are masked by rst so an abort issues nothing in its own cycle.
  always_comb begin
    state_nx  = state;
    img_rd_en = 1'b0;
    ch_start  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      LOAD_WAIT: begin
        if (load_cnt == LW'(LOAD_CYCLES - 1)) state_nx = IDLE;
      end
      IDLE: begin
        if (start || pending) state_nx = ARM;
      end
      ARM: begin
        ch_start = !rst;
        busy     = 1'b1;
        state_nx = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        img_rd_en = rd_go && !rst;
        if (rd_go && (rd_cnt == RW'(NPIX - 1))) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_ok || timeout_hit) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = LOAD_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt   <= '0;
      pending    <= 1'b0;
      rd_cnt     <= '0;
      out_cnt    <= '0;
      drain_cnt  <= '0;
      done_flags <= '0;
      error      <= 1'b0;
    end else begin
      if (state == LOAD_WAIT) load_cnt <= load_cnt + LW'(1);
      if ((state == LOAD_WAIT) && start) pending <= 1'b1;
      else if (accept)                   pending <= 1'b0;
      if (accept) begin
        rd_cnt     <= '0;
        out_cnt    <= '0;
        drain_cnt  <= '0;
        done_flags <= '0;
      end else begin
        if (rd_go)            rd_cnt     <= rd_cnt + RW'(1);
        if (wr_go)            out_cnt    <= out_cnt + 8'd1;
        if (state == DRAIN)   drain_cnt  <= drain_cnt + DW'(1);
        if (collect)          done_flags <= done_flags | ch_layer_done;
      end
      if (accept)                     error <= 1'b0;
      else if (fault || timeout_hit)  error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_valid    <= 1'b0;
      out_wr_en   <= 1'b0;
      out_wr_addr <= '0;
      out_wr_data <= '0;
    end else begin
      ch_valid  <= img_rd_en;
      out_wr_en <= wr_go;
      if (wr_go) begin
        out_wr_addr <= out_cnt;
        out_wr_data <= ch_pixel_in;
      end
    end
  end

  assign img_rd_addr = rd_cnt[9:0];
  assign ch_pixel    = ch_valid ? img_rd_data : 8'd0;

endmodule

// File: tb/tb_lenet_layer1_scheduler.sv
// Randomized bench for lenet_layer1_scheduler against a timeline model
// of frame acceptance, image reads, channel outputs and completion.
module tb_lenet_layer1_scheduler;
  localparam int N_CH  = 6;
  localparam int NPIX  = 1024;
  localparam int NOUT  = 196;
  localparam int LOADC = 32;
  localparam int TMO   = 4096;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stall;
  logic              img_rd_en;
  logic [9:0]        img_rd_addr;
  logic [7:0]        img_rd_data;
  logic              ch_start;
  logic              ch_valid;
  logic [7:0]        ch_pixel;
  logic [N_CH-1:0]   ch_valid_in;
  logic [N_CH*8-1:0] ch_pixel_in;
  logic [N_CH-1:0]   ch_layer_done;
  logic              out_wr_en;
  logic [7:0]        out_wr_addr;
  logic [N_CH*8-1:0] out_wr_data;
  logic              busy;
  logic              done;
  logic              error;

  always #5 clk = ~clk;

  lenet_layer1_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stall        (stall),
    .img_rd_en    (img_rd_en),
    .img_rd_addr  (img_rd_addr),
    .img_rd_data  (img_rd_data),
    .ch_start     (ch_start),
    .ch_valid     (ch_valid),
    .ch_pixel     (ch_pixel),
    .ch_valid_in  (ch_valid_in),
    .ch_pixel_in  (ch_pixel_in),
    .ch_layer_done(ch_layer_done),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .out_wr_data  (out_wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  logic [7:0] mem [NPIX];

  int n_chk;
  int n_pass;
  int cyc;

  bit        frame_on;
  int        arm_cyc;
  int        rd_n;
  int        last_rd;
  bit        prev_rd;
  int        prev_addr;
  int        emit_left;
  bit        extra;
  bit        bad;
  logic [5:0] withhold;
  logic [5:0] got_done;
  int        n_wr;
  int        last_v;
  int        last_f;
  bit        exp_wr;
  logic [7:0]  exp_wr_addr;
  logic [47:0] exp_wr_data;
  bit        exp_err;
  bit        req_start;
  int        stall_left;
  int        stall_at;
  bit        rand_stall;
  int        mid_start;
  int        rst_at;
  bit        frame_end;
  int        obs_rd;
  int        obs_wr;
  int        obs_done;
  int        first_rd;
  int        obs_done_cyc;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  tag, got, exp, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    start         = 1'b0;
    stall         = 1'b0;
    img_rd_data   = '0;
    ch_valid_in   = '0;
    ch_pixel_in   = '0;
    ch_layer_done = '0;
    cyc        = 0;
    frame_on   = 1'b0;
    arm_cyc    = -1;
    prev_rd    = 1'b0;
    exp_wr     = 1'b0;
    exp_err    = 1'b0;
    stall_left = 0;
    req_start  = 1'b0;
  endtask

  task automatic setup(int s_at, bit rs, bit b, bit x,
                       logic [5:0] wh, int ms, int ra);
    stall_at   = s_at;
    rand_stall = rs;
    bad        = b;
    extra      = x;
    withhold   = wh;
    mid_start  = ms;
    rst_at     = ra;
    rd_n       = 0;
    last_rd    = -1;
    n_wr       = 0;
    emit_left  = NOUT;
    got_done   = '0;
    last_v     = -1;
    last_f     = -1;
    obs_rd     = 0;
    obs_wr     = 0;
    obs_done   = 0;
    first_rd   = -1;
    obs_done_cyc = -1;
  endtask

  task automatic step();
    bit          exp_rd;
    bit          win;
    bit          wr_nx;
    bit          err_nx;
    bit          done_now;
    int          norm;
    int          tmo;
    int          tgt;
    logic [7:0]  exp_px;
    @(negedge clk);
    rst = 1'b0;
    if (frame_on && mid_start >= 0 && rd_n == mid_start) begin
      req_start = 1'b1;
      mid_start = -1;
    end
    start = req_start;
    if (req_start && !frame_on && arm_cyc < 0)
      arm_cyc = (cyc > LOADC ? cyc : LOADC) + 1;
    req_start = 1'b0;
    if (cyc == arm_cyc) begin
      frame_on = 1'b1;
      exp_err  = 1'b0;
    end
    win = frame_on && (cyc > arm_cyc);
    if (win && rd_n == stall_at) begin
      stall_left = 10;
      stall_at   = -1;
    end
    if (stall_left > 0) begin
      stall = 1'b1;
      stall_left--;
    end else begin
      stall = rand_stall && ($urandom_range(0, 5) == 0);
    end
    exp_rd = win && (rd_n < NPIX) && !stall;
    img_rd_data   = prev_rd ? mem[prev_addr] : 8'($urandom);
    ch_pixel_in   = {16'($urandom), 32'($urandom)};
    ch_valid_in   = '0;
    ch_layer_done = '0;
    wr_nx  = 1'b0;
    err_nx = exp_err;
    if (!frame_on) begin
      ch_valid_in   = 6'($urandom);
      ch_layer_done = 6'($urandom);
    end else if (win) begin
      if (bad && emit_left == 100) begin
        ch_valid_in = 6'b000111;
        err_nx      = 1'b1;
        bad         = 1'b0;
      end else if (emit_left > 0) begin
        if ($urandom_range(0, 2) == 0) begin
          ch_valid_in = '1;
          wr_nx       = 1'b1;
          emit_left--;
          last_v      = cyc;
        end
      end else if (extra) begin
        ch_valid_in = '1;
        err_nx      = 1'b1;
        extra       = 1'b0;
      end else if ((got_done | withhold) != 6'h3f) begin
        ch_layer_done = 6'($urandom) & ~withhold;
        got_done      = got_done | ch_layer_done;
        if (got_done == 6'h3f) last_f = cyc;
      end
    end
    #1;
    done_now = 1'b0;
    if (frame_on && last_rd >= 0) begin
      tmo  = last_rd + TMO + 1;
      norm = tmo + 1;
      if (n_wr == NOUT && got_done == 6'h3f) begin
        norm = last_rd + 2;
        if (last_v + 3 > norm) norm = last_v + 3;
        if (last_f + 2 > norm) norm = last_f + 2;
      end
      tgt = norm < tmo ? norm : tmo;
      done_now = (cyc == tgt);
      if (done_now && norm > tmo) begin
        exp_err = 1'b1;
        err_nx  = 1'b1;
      end
    end
    exp_px = prev_rd ? mem[prev_addr] : 8'd0;
    check("rd_en", 64'(img_rd_en), 64'(exp_rd));
    if (exp_rd) check("rd_addr", 64'(img_rd_addr), 64'(rd_n));
    check("ch_start", 64'(ch_start), 64'(cyc == arm_cyc));
    check("busy", 64'(busy), 64'(frame_on));
    check("done", 64'(done), 64'(done_now));
    check("error", 64'(error), 64'(exp_err));
    check("ch_valid", 64'(ch_valid), 64'(prev_rd));
    check("ch_pixel", 64'(ch_pixel), 64'(exp_px));
    check("wr_en", 64'(out_wr_en), 64'(exp_wr));
    if (exp_wr) begin
      check("wr_addr", 64'(out_wr_addr), 64'(exp_wr_addr));
      check("wr_data", 64'(out_wr_data), 64'(exp_wr_data));
    end
    if (cyc == 0) begin
      check("rst_rd_addr", 64'(img_rd_addr), 64'(0));
      check("rst_wr_addr", 64'(out_wr_addr), 64'(0));
      check("rst_wr_data", 64'(out_wr_data), 64'(0));
    end
    if (img_rd_en && obs_rd == 0) first_rd = cyc;
    if (img_rd_en) obs_rd++;
    if (out_wr_en) obs_wr++;
    if (done) begin
      obs_done++;
      obs_done_cyc = cyc;
    end
    prev_rd   = exp_rd;
    prev_addr = rd_n;
    if (exp_rd) begin
      if (rd_n == NPIX - 1) last_rd = cyc;
      rd_n++;
    end
    exp_wr = wr_nx;
    if (wr_nx) begin
      exp_wr_addr = 8'(n_wr);
      exp_wr_data = ch_pixel_in;
      n_wr++;
    end
    exp_err = err_nx;
    if (done_now) begin
      frame_on  = 1'b0;
      arm_cyc   = -1;
      frame_end = 1'b1;
    end
    cyc++;
  endtask

  task automatic run_frame(int budget);
    int n;
    n = 0;
    frame_end = 1'b0;
    while (!frame_end && n < budget) begin
      if (rst_at >= 0 && frame_on && rd_n == rst_at) begin
        do_reset();
        rst_at = -1;
        return;
      end
      step();
      n++;
    end
    check("frame_budget", 64'(frame_end), 64'(1));
  endtask

  task automatic end_checks(bit err);
    check("n_reads", 64'(obs_rd), 64'(NPIX));
    check("n_writes", 64'(obs_wr), 64'(NOUT));
    check("n_done", 64'(obs_done), 64'(1));
    check("err_end", 64'(error), 64'(err));
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    stall     = 1'b0;
    mid_start = -1;
    rst_at    = -1;
    stall_at  = -1;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    repeat (3) do_reset();

    setup(-1, 1'b0, 1'b0, 1'b0, 6'h00, -1, -1);
    repeat (5) step();
    req_start = 1'b1;
    run_frame(3000);
    end_checks(1'b0);
    check("first_rd_cyc", 64'(first_rd), 64'(LOADC + 2));

    setup(500, 1'b0, 1'b1, 1'b0, 6'h00, 700, -1);
    req_start = 1'b1;
    run_frame(3000);
    end_checks(1'b1);

    setup(-1, 1'b1, 1'b0, 1'b1, 6'h00, -1, -1);
    req_start = 1'b1;
    run_frame(4000);
    end_checks(1'b1);

    setup(-1, 1'b0, 1'b0, 1'b0, 6'b001000, -1, -1);
    req_start = 1'b1;
    run_frame(8000);
    end_checks(1'b1);
    check("tmo_span", 64'(obs_done_cyc - last_rd), 64'(TMO + 1));

    setup(-1, 1'b1, 1'b0, 1'b0, 6'h00, -1, 300);
    req_start = 1'b1;
    run_frame(3000);

    setup(-1, 1'b1, 1'b0, 1'b0, 6'h00, -1, -1);
    req_start = 1'b1;
    run_frame(4000);
    end_checks(1'b0);
    check("first_rd_rst", 64'(first_rd), 64'(LOADC + 2));

    repeat (5) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
